// File: rtl/fpu_operand_unpack_pkg.sv
// Shared FPU definitions: class flag encoding, format derivation helpers and
// the unpack stage FSM state type.
package fpu_operand_unpack_pkg;

    localparam int CLASS_BIT_SNAN = 0;
    localparam int CLASS_BIT_QNAN = 1;
    localparam int CLASS_BIT_INF  = 2;
    localparam int CLASS_BIT_ZERO = 3;
    localparam int CLASS_BIT_SUB  = 4;
    localparam int CLASS_BIT_NORM = 5;

    localparam logic [5:0] CLASS_SNAN = 6'b000001;
    localparam logic [5:0] CLASS_QNAN = 6'b000010;
    localparam logic [5:0] CLASS_INF  = 6'b000100;
    localparam logic [5:0] CLASS_ZERO = 6'b001000;
    localparam logic [5:0] CLASS_SUB  = 6'b010000;
    localparam logic [5:0] CLASS_NORM = 6'b100000;

    // Exponent and fraction field widths for binary32 / binary64.
    function automatic int fpu_nexp(input int flen);
        return (flen == 64) ? 11 : 8;
    endfunction

    function automatic int fpu_nsig(input int flen);
        return flen - 1 - fpu_nexp(flen);
    endfunction

    function automatic int fpu_emax(input int flen);
        return (1 << (fpu_nexp(flen) - 1)) - 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NORM,
        ST_DONE
    } state_t;

endpackage

// File: rtl/fpu_operand_unpack_if.sv
// Handshake and data bundle of the operand unpack stage; master is the
// upstream/downstream environment, slave is the unpack stage itself.
interface fpu_operand_unpack_if
    import fpu_operand_unpack_pkg::*;
#(
    parameter int FLEN = 32
);
    localparam int NEXP = fpu_nexp(FLEN);
    localparam int NSIG = fpu_nsig(FLEN);

    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [FLEN-1:0]        rs1_i;
    logic [FLEN-1:0]        rs2_i;
    logic [2:0]             rm_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [FLEN-1:0]        rs1_o;
    logic [FLEN-1:0]        rs2_o;
    logic signed [NEXP+1:0] rs1Exp_o;
    logic signed [NEXP+1:0] rs2Exp_o;
    logic [NSIG:0]          rs1Sig_o;
    logic [NSIG:0]          rs2Sig_o;
    logic [5:0]             rs1Class_o;
    logic [5:0]             rs2Class_o;
    logic [2:0]             rm_o;

    modport master (
        output in_valid_i, rs1_i, rs2_i, rm_i, out_ready_i,
        input  in_ready_o, out_valid_o, rs1_o, rs2_o, rs1Exp_o, rs2Exp_o,
               rs1Sig_o, rs2Sig_o, rs1Class_o, rs2Class_o, rm_o
    );

    modport slave (
        input  in_valid_i, rs1_i, rs2_i, rm_i, out_ready_i,
        output in_ready_o, out_valid_o, rs1_o, rs2_o, rs1Exp_o, rs2Exp_o,
               rs1Sig_o, rs2Sig_o, rs1Class_o, rs2Class_o, rm_o
    );

endinterface

// File: rtl/fpu_operand_unpack_classify.sv
// Combinational classifier: magnitude bits of one raw operand -> one-hot
// class, initial unbiased exponent and significand with explicit hidden bit.
module fpu_classify
    import fpu_operand_unpack_pkg::*;
#(
    parameter int FLEN = 32
) (
    input  logic [FLEN-2:0]                  mag,
    output logic [5:0]                       cls,
    output logic signed [fpu_nexp(FLEN)+1:0] exp,
    output logic [fpu_nsig(FLEN):0]          sig
);
    localparam int NEXP = fpu_nexp(FLEN);
    localparam int NSIG = fpu_nsig(FLEN);
    localparam int EMAX = fpu_emax(FLEN);
    localparam int EW   = NEXP + 2;

    logic [NEXP-1:0] e_field;
    logic [NSIG-1:0] f_field;

    assign e_field = mag[FLEN-2 -: NEXP];
    assign f_field = mag[NSIG-1:0];

    always_comb begin
        cls = '0;
        exp = '0;
        sig = '0;
        if (e_field == '1) begin
            exp = EW'(EMAX + 1);
            sig = {1'b0, f_field};
            if (f_field == '0)
                cls[CLASS_BIT_INF] = 1'b1;
            else if (f_field[NSIG-1])
                cls[CLASS_BIT_QNAN] = 1'b1;
            else
                cls[CLASS_BIT_SNAN] = 1'b1;
        end else if (e_field == '0) begin
            if (f_field == '0) begin
                cls[CLASS_BIT_ZERO] = 1'b1;
            end else begin
                // Subnormals start at EMIN and are normalised by the FSM.
                cls[CLASS_BIT_SUB] = 1'b1;
                exp = EW'(1 - EMAX);
                sig = {1'b0, f_field};
            end
        end else begin
            cls[CLASS_BIT_NORM] = 1'b1;
            exp = $signed({2'b00, e_field}) - EW'(EMAX);
            sig = {1'b1, f_field};
        end
    end

endmodule

// File: rtl/fpu_operand_unpack.sv
// FPU front-end: accepts two raw operands, classifies/unpacks them and
// normalises subnormal significands one bit per cycle before presenting them.
module fpu_operand_unpack
    import fpu_operand_unpack_pkg::*;
#(
    parameter int FLEN = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    fpu_operand_unpack_if.slave bus
);
    localparam int NEXP = fpu_nexp(FLEN);
    localparam int NSIG = fpu_nsig(FLEN);
    localparam int EW   = NEXP + 2;

    state_t                state_reg;
    logic [2:0]            rm_reg;
    logic [FLEN-1:0]       raw      [2];
    logic [FLEN-1:0]       raw_reg  [2];
    logic [5:0]            cls_init [2];
    logic [5:0]            cls_reg  [2];
    logic signed [EW-1:0]  exp_init [2];
    logic signed [EW-1:0]  exp_reg  [2];
    logic [NSIG:0]         sig_init [2];
    logic [NSIG:0]         sig_reg  [2];
    logic [NSIG:0]         sig_next [2];
    logic                  shift    [2];
    logic                  settled  [2];
    logic                  accept;

    assign raw[0] = bus.rs1_i;
    assign raw[1] = bus.rs2_i;
    assign accept = (state_reg == ST_IDLE) && bus.in_valid_i && !flush_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            fpu_classify #(.FLEN(FLEN)) u_classify (
                .mag (raw[gi][FLEN-2:0]),
                .cls (cls_init[gi]),
                .exp (exp_init[gi]),
                .sig (sig_init[gi])
            );

            assign shift[gi]    = cls_reg[gi][CLASS_BIT_SUB] && !sig_reg[gi][NSIG];
            assign sig_next[gi] = shift[gi] ? (sig_reg[gi] << 1) : sig_reg[gi];
            // Operand is finished once the shift about to happen exposes the leading 1.
            assign settled[gi]  = !cls_reg[gi][CLASS_BIT_SUB] || sig_next[gi][NSIG];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else if (flush_i) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.in_valid_i)
                        state_reg <= (cls_init[0][CLASS_BIT_SUB] || cls_init[1][CLASS_BIT_SUB])
                                     ? ST_NORM : ST_DONE;
                end
                ST_NORM: begin
                    if (settled[0] && settled[1])
                        state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready_i)
                        state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rm_reg <= '0;
            for (int i = 0; i < 2; i++) begin
                raw_reg[i] <= '0;
                cls_reg[i] <= '0;
                exp_reg[i] <= '0;
                sig_reg[i] <= '0;
            end
        end else if (accept) begin
            rm_reg <= bus.rm_i;
            for (int i = 0; i < 2; i++) begin
                raw_reg[i] <= raw[i];
                cls_reg[i] <= cls_init[i];
                exp_reg[i] <= exp_init[i];
                sig_reg[i] <= sig_init[i];
            end
        end else if (state_reg == ST_NORM && !flush_i) begin
            for (int i = 0; i < 2; i++) begin
                sig_reg[i] <= sig_next[i];
                if (shift[i])
                    exp_reg[i] <= exp_reg[i] - EW'(1);
            end
        end
    end

    assign bus.in_ready_o  = (state_reg == ST_IDLE);
    assign bus.out_valid_o = (state_reg == ST_DONE);
    assign bus.rs1_o       = raw_reg[0];
    assign bus.rs2_o       = raw_reg[1];
    assign bus.rs1Exp_o    = exp_reg[0];
    assign bus.rs2Exp_o    = exp_reg[1];
    assign bus.rs1Sig_o    = sig_reg[0];
    assign bus.rs2Sig_o    = sig_reg[1];
    assign bus.rs1Class_o  = cls_reg[0];
    assign bus.rs2Class_o  = cls_reg[1];
    assign bus.rm_o        = rm_reg;

endmodule

// File: tb/tb_fpu_operand_unpack.sv
// Directed bench for fpu_operand_unpack: binary32 vector table plus hand
// sequences for backpressure, flush, reset and a binary64 subnormal.
module tb_fpu_operand_unpack;
    import fpu_operand_unpack_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fpu_operand_unpack_if #(.FLEN(32)) bus32 ();
    fpu_operand_unpack_if #(.FLEN(64)) bus64 ();

    fpu_operand_unpack #(.FLEN(32)) dut32 (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus32.slave)
    );

    fpu_operand_unpack #(.FLEN(64)) dut64 (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus64.slave)
    );

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [2:0]  rm;
        int          lat;
        int          e1;
        logic [23:0] s1;
        logic [5:0]  c1;
        int          e2;
        logic [23:0] s2;
        logic [5:0]  c2;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Accept one binary32 pair, measure latency, compare, then release.
    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        @(negedge clk);
        chk("in_ready_before_accept", longint'(bus32.in_ready_o), 1);
        bus32.rs1_i      = v.rs1;
        bus32.rs2_i      = v.rs2;
        bus32.rm_i       = v.rm;
        bus32.in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus32.in_valid_i = 1'b0;
        lat = 1;
        while (!bus32.out_valid_o && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency",    longint'(lat), longint'(v.lat));
        chk("rs1_o",      longint'(bus32.rs1_o), longint'(v.rs1));
        chk("rs2_o",      longint'(bus32.rs2_o), longint'(v.rs2));
        chk("rm_o",       longint'(bus32.rm_o), longint'(v.rm));
        chk("rs1Exp",     longint'(bus32.rs1Exp_o), longint'(v.e1));
        chk("rs1Sig",     longint'(bus32.rs1Sig_o), longint'(v.s1));
        chk("rs1Class",   longint'(bus32.rs1Class_o), longint'(v.c1));
        chk("rs2Exp",     longint'(bus32.rs2Exp_o), longint'(v.e2));
        chk("rs2Sig",     longint'(bus32.rs2Sig_o), longint'(v.s2));
        chk("rs2Class",   longint'(bus32.rs2Class_o), longint'(v.c2));
        $display("vec %0d: rs1=%h rs2=%h lat=%0d exp1=%0d exp2=%0d cls1=%b cls2=%b",
                 idx, v.rs1, v.rs2, lat, bus32.rs1Exp_o, bus32.rs2Exp_o,
                 bus32.rs1Class_o, bus32.rs2Class_o);
        @(negedge clk);
        bus32.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus32.out_ready_i = 1'b0;
        chk("release_out_valid", longint'(bus32.out_valid_o), 0);
        chk("release_in_ready",  longint'(bus32.in_ready_o), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic seen;

        //         rs1           rs2           rm    lat  e1    s1          c1          e2    s2          c2
        vecs[0] = '{32'h3F800000, 32'hC0000000, 3'd0, 1,   0,    24'h800000, CLASS_NORM, 1,    24'h800000, CLASS_NORM};
        vecs[1] = '{32'h00000001, 32'h00400000, 3'd1, 24,  -149, 24'h800000, CLASS_SUB,  -127, 24'h800000, CLASS_SUB};
        vecs[2] = '{32'h7F800001, 32'h7FC00000, 3'd2, 1,   128,  24'h000001, CLASS_SNAN, 128,  24'h400000, CLASS_QNAN};
        vecs[3] = '{32'h7F800000, 32'h00000000, 3'd3, 1,   128,  24'h000000, CLASS_INF,  0,    24'h000000, CLASS_ZERO};
        vecs[4] = '{32'h00000003, 32'h3F800000, 3'd4, 23,  -148, 24'hC00000, CLASS_SUB,  0,    24'h800000, CLASS_NORM};
        vecs[5] = '{32'h80000000, 32'h7F7FFFFF, 3'd7, 1,   0,    24'h000000, CLASS_ZERO, 127,  24'hFFFFFF, CLASS_NORM};
        vecs[6] = '{32'h00800000, 32'h807FFFFF, 3'd5, 2,   -126, 24'h800000, CLASS_NORM, -127, 24'hFFFFFE, CLASS_SUB};
        vecs[7] = '{32'hFFC00001, 32'hFF800000, 3'd6, 1,   128,  24'h400001, CLASS_QNAN, 128,  24'h000000, CLASS_INF};

        rst = 1'b1;
        flush = 1'b0;
        bus32.in_valid_i = 1'b0; bus32.out_ready_i = 1'b0;
        bus32.rs1_i = '0; bus32.rs2_i = '0; bus32.rm_i = '0;
        bus64.in_valid_i = 1'b0; bus64.out_ready_i = 1'b0;
        bus64.rs1_i = '0; bus64.rs2_i = '0; bus64.rm_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_in_ready",  longint'(bus32.in_ready_o), 1);
        chk("reset_out_valid", longint'(bus32.out_valid_o), 0);
        chk("reset_rs1_o",     longint'(bus32.rs1_o), 0);
        chk("reset_rs1Sig",    longint'(bus32.rs1Sig_o), 0);
        chk("reset_rs2Class",  longint'(bus32.rs2Class_o), 0);
        chk("reset_rm_o",      longint'(bus32.rm_o), 0);

        for (int i = 0; i < 8; i++)
            run_vec(i, vecs[i]);

        // Backpressure: hold DONE with stray in_valid pulses.
        @(negedge clk);
        bus32.rs1_i = 32'h40400000; bus32.rs2_i = 32'h3F800000; bus32.rm_i = 3'd2;
        bus32.in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus32.in_valid_i = 1'b0;
        chk("bp_accept_valid", longint'(bus32.out_valid_o), 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus32.rs1_i = 32'h00000001 + 32'(c);
            bus32.in_valid_i = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_out_valid", longint'(bus32.out_valid_o), 1);
            chk("bp_in_ready",  longint'(bus32.in_ready_o), 0);
            chk("bp_rs1_o",     longint'(bus32.rs1_o), 64'h40400000);
            chk("bp_rs1Exp",    longint'(bus32.rs1Exp_o), 1);
            chk("bp_rs1Sig",    longint'(bus32.rs1Sig_o), 64'hC00000);
        end
        $display("backpressure: held 5 cycles rs1_o=%h", bus32.rs1_o);
        @(negedge clk);
        bus32.in_valid_i = 1'b0;
        bus32.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus32.out_ready_i = 1'b0;
        chk("bp_release_valid", longint'(bus32.out_valid_o), 0);
        chk("bp_release_ready", longint'(bus32.in_ready_o), 1);

        // Flush beats in_valid in IDLE.
        @(negedge clk);
        bus32.rs1_i = 32'h3F800000; bus32.in_valid_i = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        bus32.in_valid_i = 1'b0; flush = 1'b0;
        chk("flush_prio_ready", longint'(bus32.in_ready_o), 1);
        chk("flush_prio_valid", longint'(bus32.out_valid_o), 0);
        $display("flush priority: in_ready=%0b out_valid=%0b", bus32.in_ready_o, bus32.out_valid_o);

        // Flush in the middle of normalisation.
        @(negedge clk);
        bus32.rs1_i = 32'h00000001; bus32.rs2_i = 32'h00000000; bus32.rm_i = 3'd6;
        bus32.in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus32.in_valid_i = 1'b0;
        chk("norm_busy", longint'(bus32.in_ready_o), 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_in_ready",  longint'(bus32.in_ready_o), 1);
        chk("flush_out_valid", longint'(bus32.out_valid_o), 0);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus32.out_valid_o) seen = 1'b1;
        end
        chk("flush_no_valid_later", longint'(seen), 0);
        $display("flush mid-norm: out_valid seen=%0b", seen);

        // Reset in the middle of normalisation.
        @(negedge clk);
        bus32.rs1_i = 32'h00000001; bus32.rs2_i = 32'h00000000; bus32.rm_i = 3'd6;
        bus32.in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus32.in_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready",  longint'(bus32.in_ready_o), 1);
        chk("rst_out_valid", longint'(bus32.out_valid_o), 0);
        chk("rst_rs1_o",     longint'(bus32.rs1_o), 0);
        chk("rst_rs1Exp",    longint'(bus32.rs1Exp_o), 0);
        chk("rst_rs1Sig",    longint'(bus32.rs1Sig_o), 0);
        chk("rst_rs1Class",  longint'(bus32.rs1Class_o), 0);
        chk("rst_rm_o",      longint'(bus32.rm_o), 0);
        $display("reset mid-norm: rs1_o=%h rm_o=%0d", bus32.rs1_o, bus32.rm_o);

        // binary64 smallest subnormal alongside 1.0.
        @(negedge clk);
        bus64.rs1_i = 64'h0000000000000001; bus64.rs2_i = 64'h3FF0000000000000;
        bus64.rm_i = 3'd1; bus64.in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus64.in_valid_i = 1'b0;
        lat = 1;
        while (!bus64.out_valid_o && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("f64_latency",  longint'(lat), 53);
        chk("f64_rs1Exp",   longint'(bus64.rs1Exp_o), -1074);
        chk("f64_rs1Sig",   longint'(bus64.rs1Sig_o), 64'h0010000000000000);
        chk("f64_rs1Class", longint'(bus64.rs1Class_o), longint'(CLASS_SUB));
        chk("f64_rs2Exp",   longint'(bus64.rs2Exp_o), 0);
        chk("f64_rs2Sig",   longint'(bus64.rs2Sig_o), 64'h0010000000000000);
        chk("f64_rs2Class", longint'(bus64.rs2Class_o), longint'(CLASS_NORM));
        chk("f64_rm_o",     longint'(bus64.rm_o), 1);
        $display("f64: lat=%0d exp1=%0d sig1=%h", lat, bus64.rs1Exp_o, bus64.rs1Sig_o);
        @(negedge clk);
        bus64.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus64.out_ready_i = 1'b0;
        chk("f64_release_ready", longint'(bus64.in_ready_o), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
